instr_fetch: RTL



---
 rtl/fetch_pkg.sv | 20 ++
 rtl/instr_fetch_if.sv | 38 +++
 rtl/instr_mem.sv | 24 ++
 rtl/instr_fetch.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Used by both builds (with and without FETCH_STEP_EN).
package fetch_pkg;

   localparam int unsigned INSTR_WIDTH = 20;
   localparam int unsigned ADDR_BITS   = 5;
   localparam int unsigned OP_HI       = 19;
   localparam int unsigned OP_LO       = 16;

   localparam logic [3:0]  OP_HALT   = 4'hF;
   localparam logic [19:0] INSTR_NOP = 20'hE0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DONE  = 2'd2,
      ST_PAUSE = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Host-side bus of instr_fetch: program loading, run control and fetched word.
// The step signal exists only when FETCH_STEP_EN is defined.
interface instr_fetch_if #(
   parameter int unsigned INSTR_WIDTH = 20,
   parameter int unsigned ADDR_BITS   = 5
) ();

   logic                   load_en;
   logic [ADDR_BITS-1:0]   load_addr;
   logic [INSTR_WIDTH-1:0] load_data;
   logic                   start;
   logic                   halt_req;
`ifdef FETCH_STEP_EN
   logic                   step;
`endif
   logic [INSTR_WIDTH-1:0] instruction;
   logic                   instr_valid;
   logic [ADDR_BITS-1:0]   pc;
   logic                   busy;
   logic                   done;

   modport master (
`ifdef FETCH_STEP_EN
      output step,
`endif
      output load_en, load_addr, load_data, start, halt_req,
      input  instruction, instr_valid, pc, busy, done
   );

   modport slave (
`ifdef FETCH_STEP_EN
      input  step,
`endif
      input  load_en, load_addr, load_data, start, halt_req,
      output instruction, instr_valid, pc, busy, done
   );

endinterface

// File: rtl/instr_mem.sv
// Program store: synchronous write, combinational read, contents not reset.
module instr_mem #(
   parameter int unsigned INSTR_WIDTH = 20,
   parameter int unsigned ADDR_BITS   = 5
) (
   input  logic                   i_clk,
   input  logic                   i_we,
   input  logic [ADDR_BITS-1:0]   i_waddr,
   input  logic [INSTR_WIDTH-1:0] i_wdata,
   input  logic [ADDR_BITS-1:0]   i_raddr,
   output logic [INSTR_WIDTH-1:0] o_rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_BITS;

   logic [INSTR_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage feeding simple_cpu: loadable program store plus run FSM.
// FETCH_STEP_EN adds the step input and a PAUSE state for single-stepping.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int unsigned INSTR_WIDTH = fetch_pkg::INSTR_WIDTH,
   parameter int unsigned ADDR_BITS   = fetch_pkg::ADDR_BITS
) (
   input  logic         clk,
   input  logic         rst,
   instr_fetch_if.slave bus
);

   localparam int unsigned CNT_W = ADDR_BITS + 1;

   fetch_state_e r_state;
   fetch_state_e w_state_nxt;

   logic [CNT_W-1:0]       r_count;
   logic [CNT_W-1:0]       r_prog_len;
   logic [INSTR_WIDTH-1:0] r_instr;
   logic                   r_valid;
   logic                   r_busy;
   logic                   r_done;

   logic [CNT_W-1:0]       w_count_nxt;
   logic [INSTR_WIDTH-1:0] w_instr_nxt;
   logic                   w_valid_nxt;
   logic                   w_idle_like;
   logic                   w_load_ok;
   logic [CNT_W-1:0]       w_load_len;
   logic [CNT_W-1:0]       w_prog_len_upd;
   logic [INSTR_WIDTH-1:0] w_rd_data;
   logic                   w_stop;
   logic                   w_step;
   fetch_state_e           w_run_state;

   assign w_idle_like    = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign w_load_ok      = bus.load_en && w_idle_like;
   assign w_load_len     = CNT_W'(bus.load_addr) + CNT_W'(1);
   assign w_prog_len_upd = (w_load_ok && (w_load_len > r_prog_len)) ? w_load_len : r_prog_len;

   instr_mem #(
      .INSTR_WIDTH (INSTR_WIDTH),
      .ADDR_BITS   (ADDR_BITS)
   ) u_mem (
      .i_clk   (clk),
      .i_we    (w_load_ok),
      .i_waddr (bus.load_addr),
      .i_wdata (bus.load_data),
      .i_raddr (r_count[ADDR_BITS-1:0]),
      .o_rdata (w_rd_data)
   );

   // The wrapped read address at count==prog_len is harmless: the end check wins.
   assign w_stop = bus.halt_req
                || (r_count == r_prog_len)
                || (w_rd_data[OP_HI:OP_LO] == OP_HALT);

`ifdef FETCH_STEP_EN
   assign w_step      = bus.step;
   assign w_run_state = ST_PAUSE;
`else
   assign w_step      = 1'b0;
   assign w_run_state = ST_RUN;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (bus.start)
               w_state_nxt = (w_prog_len_upd == '0) ? ST_DONE : w_run_state;
         end
         ST_RUN: begin
            if (w_stop) w_state_nxt = ST_DONE;
         end
         ST_PAUSE: begin
            if (bus.halt_req || (w_step && w_stop)) w_state_nxt = ST_DONE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      w_instr_nxt = INSTR_WIDTH'(INSTR_NOP);
      w_valid_nxt = 1'b0;
      w_count_nxt = r_count;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (bus.start) w_count_nxt = '0;
         end
         ST_RUN: begin
            if (!w_stop) begin
               w_instr_nxt = w_rd_data;
               w_valid_nxt = 1'b1;
               w_count_nxt = r_count + CNT_W'(1);
            end
         end
         ST_PAUSE: begin
            if (w_step && !w_stop) begin
               w_instr_nxt = w_rd_data;
               w_valid_nxt = 1'b1;
               w_count_nxt = r_count + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Registered outputs and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count    <= '0;
         r_prog_len <= '0;
         r_instr    <= INSTR_WIDTH'(INSTR_NOP);
         r_valid    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_count    <= w_count_nxt;
         r_prog_len <= w_prog_len_upd;
         r_instr    <= w_instr_nxt;
         r_valid    <= w_valid_nxt;
         r_busy     <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_PAUSE);
         r_done     <= (w_state_nxt == ST_DONE);
      end
   end

   assign bus.instruction = r_instr;
   assign bus.instr_valid = r_valid;
   assign bus.pc          = r_count[ADDR_BITS-1:0];
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;

endmodule
